// File: rtl/axi_cache_bridge_mp_pkg.sv
// Shared AXI constants, FSM encodings and address-split helper for the
// multi-port cache-to-AXI3 bridge.
package axi_bridge_pkg;

   localparam logic [1:0] BURST_INCR     = 2'b01;
   localparam logic [2:0] SIZE_WORD      = 3'b010;
   localparam int         LINE_WORDS_DEF = 4;
   localparam int         OFF_BITS       = $clog2(4 * LINE_WORDS_DEF);

   typedef enum logic {
      AR_IDLE = 1'b0,
      AR_SEND = 1'b1
   } ar_state_t;

   typedef enum logic [2:0] {
      W_IDLE = 3'd0,
      W_BOTH = 3'd1,
      W_DATA = 3'd2,
      W_ADDR = 3'd3,
      W_RESP = 3'd4
   } w_state_t;

   // Byte-offset width of a cache line holding line_words 32-bit words.
   function automatic int off_bits(input int line_words);
      return $clog2(4 * line_words);
   endfunction

endpackage

// File: rtl/axi_cache_bridge_mp_if.sv
// AXI3 master bus bundle (AR/R/AW/W/B) between the bridge and the SoC crossbar.
interface axi_cache_bridge_mp_if;
   import axi_bridge_pkg::*;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;

   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/axi_cache_bridge_mp_rr_arbiter.sv
// N-way round-robin arbiter: search starts at the pointer, masked requesters
// are skipped, and the pointer moves past the winner when advance is pulsed.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          aclk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic          advance,
   input  logic [IW-1:0] last_idx,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   logic [IW-1:0] ptr_r;

   // Pointer register: next search starts one past the last served index.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         ptr_r <= '0;
      end else if (advance) begin
         ptr_r <= (int'(last_idx) == N - 1) ? '0 : last_idx + IW'(1);
      end
   end

   // First eligible requester at or after the pointer, wrapping modulo N.
   always_comb begin
      logic [IW:0]   sum_s;
      logic [IW-1:0] idx_s;
      logic          hit_s;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      sum_s     = '0;
      idx_s     = '0;
      hit_s     = 1'b0;
      for (int k = 0; k < N; k++) begin
         sum_s = {1'b0, ptr_r} + (IW+1)'(k);
         if (sum_s >= (IW+1)'(N)) begin
            sum_s = sum_s - (IW+1)'(N);
         end else begin
            sum_s = sum_s;
         end
         idx_s        = sum_s[IW-1:0];
         hit_s        = !any && req[idx_s] && mask[idx_s];
         grant[idx_s] = grant[idx_s] | hit_s;
         grant_idx    = hit_s ? idx_s : grant_idx;
         any          = any | hit_s;
      end
   end

endmodule

// File: rtl/axi_cache_bridge_mp.sv
// Multi-port L1 cache to AXI3 bridge: round-robin line/word reads with bounded
// outstanding count and ID-routed returns, plus one line-writeback port.
module axi_cache_bridge_mp
   import axi_bridge_pkg::*;
#(
   parameter int N_RD       = 2,
   parameter int LINE_WORDS = 4,
   parameter int MAX_OUTST  = 2
) (
   input  logic                    aclk,
   input  logic                    reset,
   input  logic [N_RD-1:0]         rd_req,
   input  logic [3*N_RD-1:0]       rd_type,
   input  logic [32*N_RD-1:0]      rd_addr,
   output logic [N_RD-1:0]         rd_rdy,
   output logic [N_RD-1:0]         ret_valid,
   output logic [N_RD-1:0]         ret_last,
   output logic [32*N_RD-1:0]      ret_data,
   input  logic                    wr_req,
   input  logic [2:0]              wr_type,
   input  logic [31:0]             wr_addr,
   input  logic [3:0]              wr_wstrb,
   input  logic [32*LINE_WORDS-1:0] wr_data,
   output logic                    wr_rdy,
   axi_cache_bridge_mp_if.master   axi
);

   localparam int IW = (N_RD > 1) ? $clog2(N_RD) : 1;
   localparam int OB = off_bits(LINE_WORDS);

   ar_state_t     ar_state_r, ar_state_nxt_s;
   w_state_t      w_state_r, w_state_nxt_s;
   logic [3:0]    outst_r;
   logic [3:0]    arid_r;
   logic [31:0]   araddr_r;
   logic [7:0]    arlen_r;
   logic [2:0]    arsize_r;
   logic [N_RD-1:0] grant_s, hazard_s;
   logic [IW-1:0] grant_idx_s;
   logic          grant_any_s, rd_open_s, rd_hs_s, ar_hs_s, r_last_s;
   logic [2:0]    sel_type_s;
   logic [31:0]   sel_addr_s;
   logic [N_RD-1:0] ret_valid_r, ret_last_r;
   logic [31:0]   ret_data_r [N_RD];
   logic [31:0]   awaddr_r;
   logic [7:0]    awlen_r;
   logic [2:0]    awsize_r;
   logic [3:0]    wstrb_r, beat_r;
   logic [31:0]   line_r [LINE_WORDS];
   logic [31:0]   wdata_s;
   logic          wr_hs_s, wr_pend_s, w_hs_s, wlast_s;
   logic          awvalid_s, wvalid_s, bready_s;
   logic          unused_s;

   assign unused_s = ^{axi.rresp, axi.bid, axi.bresp, grant_any_s};

   // Reads touching the line of a pending writeback must wait for its response.
   always_comb begin
      hazard_s = '0;
      for (int i = 0; i < N_RD; i++) begin
         hazard_s[i] = wr_pend_s && (rd_addr[32*i+OB +: 32-OB] == awaddr_r[31:OB]);
      end
   end

   rr_arbiter #(.N(N_RD), .IW(IW)) u_arb (
      .aclk      (aclk),
      .reset     (reset),
      .req       (rd_req),
      .mask      (~hazard_s),
      .advance   (ar_hs_s),
      .last_idx  (arid_r[IW-1:0]),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .any       (grant_any_s)
   );

   assign rd_open_s = (ar_state_r == AR_IDLE) && (outst_r < 4'(MAX_OUTST)) && !reset;
   assign rd_rdy    = grant_s & {N_RD{rd_open_s}};
   assign rd_hs_s   = |(rd_req & rd_rdy);
   assign ar_hs_s   = axi.arvalid & axi.arready;
   assign r_last_s  = axi.rvalid & axi.rlast;

   // Type and address of the granted port.
   always_comb begin
      sel_type_s = '0;
      sel_addr_s = '0;
      for (int i = 0; i < N_RD; i++) begin
         sel_type_s = sel_type_s | (rd_type[3*i +: 3] & {3{grant_s[i]}});
         sel_addr_s = sel_addr_s | (rd_addr[32*i +: 32] & {32{grant_s[i]}});
      end
   end

   // AR and write FSM state registers.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         ar_state_r <= AR_IDLE;
         w_state_r  <= W_IDLE;
      end else begin
         ar_state_r <= ar_state_nxt_s;
         w_state_r  <= w_state_nxt_s;
      end
   end

   // AR next state.
   always_comb begin
      ar_state_nxt_s = ar_state_r;
      case (ar_state_r)
         AR_IDLE: ar_state_nxt_s = rd_hs_s ? AR_SEND : AR_IDLE;
         AR_SEND: ar_state_nxt_s = axi.arready ? AR_IDLE : AR_SEND;
         default: ar_state_nxt_s = AR_IDLE;
      endcase
   end

   // AR payload held stable from grant until accepted.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         arid_r   <= 4'd0;
         araddr_r <= 32'd0;
         arlen_r  <= 8'd0;
         arsize_r <= 3'd0;
      end else if (rd_hs_s) begin
         arid_r   <= 4'(grant_idx_s);
         araddr_r <= sel_addr_s;
         arlen_r  <= sel_type_s[2] ? 8'(LINE_WORDS - 1) : 8'd0;
         arsize_r <= sel_type_s[2] ? SIZE_WORD : {1'b0, sel_type_s[1:0]};
      end
   end

   // Outstanding reads: a concurrent accept and final beat cancel out.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         outst_r <= 4'd0;
      end else begin
         case ({ar_hs_s, r_last_s && (outst_r != 4'd0)})
            2'b10:   outst_r <= outst_r + 4'd1;
            2'b01:   outst_r <= outst_r - 4'd1;
            default: outst_r <= outst_r;
         endcase
      end
   end

   // Return routing by rid; beats with an rid beyond the port count fall through.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         ret_valid_r <= '0;
         ret_last_r  <= '0;
         for (int i = 0; i < N_RD; i++) ret_data_r[i] <= 32'd0;
      end else begin
         ret_valid_r <= '0;
         ret_last_r  <= '0;
         for (int i = 0; i < N_RD; i++) begin
            if (axi.rvalid && (axi.rid == 4'(i))) begin
               ret_valid_r[i] <= 1'b1;
               ret_last_r[i]  <= axi.rlast;
               ret_data_r[i]  <= axi.rdata;
            end
         end
      end
   end

   // Flatten return data onto the packed port bus.
   always_comb begin
      ret_data = '0;
      for (int i = 0; i < N_RD; i++) ret_data[32*i +: 32] = ret_data_r[i];
   end

   assign ret_valid = ret_valid_r;
   assign ret_last  = ret_last_r;

   assign wr_rdy    = (w_state_r == W_IDLE) && !reset;
   assign wr_hs_s   = wr_req & wr_rdy;
   assign wr_pend_s = (w_state_r != W_IDLE);
   assign w_hs_s    = axi.wvalid & axi.wready;
   assign wlast_s   = (beat_r == awlen_r[3:0]);

   // Write next state and channel valids; AW and W may complete in either order.
   always_comb begin
      w_state_nxt_s = w_state_r;
      awvalid_s     = 1'b0;
      wvalid_s      = 1'b0;
      bready_s      = 1'b0;
      case (w_state_r)
         W_IDLE: w_state_nxt_s = wr_hs_s ? W_BOTH : W_IDLE;
         W_BOTH: begin
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
            if (axi.awready && axi.wready && wlast_s) begin
               w_state_nxt_s = W_RESP;
            end else if (axi.awready) begin
               w_state_nxt_s = W_DATA;
            end else if (axi.wready && wlast_s) begin
               w_state_nxt_s = W_ADDR;
            end else begin
               w_state_nxt_s = W_BOTH;
            end
         end
         W_DATA: begin
            wvalid_s      = 1'b1;
            w_state_nxt_s = (axi.wready && wlast_s) ? W_RESP : W_DATA;
         end
         W_ADDR: begin
            awvalid_s     = 1'b1;
            w_state_nxt_s = axi.awready ? W_RESP : W_ADDR;
         end
         W_RESP: begin
            bready_s      = 1'b1;
            w_state_nxt_s = axi.bvalid ? W_IDLE : W_RESP;
         end
         default: w_state_nxt_s = W_IDLE;
      endcase
   end

   // Write payload capture and beat index.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         awaddr_r <= 32'd0;
         awlen_r  <= 8'd0;
         awsize_r <= 3'd0;
         wstrb_r  <= 4'd0;
         beat_r   <= 4'd0;
         for (int i = 0; i < LINE_WORDS; i++) line_r[i] <= 32'd0;
      end else if (wr_hs_s) begin
         awaddr_r <= wr_addr;
         awlen_r  <= wr_type[2] ? 8'(LINE_WORDS - 1) : 8'd0;
         awsize_r <= wr_type[2] ? SIZE_WORD : {1'b0, wr_type[1:0]};
         wstrb_r  <= wr_type[2] ? 4'hF : wr_wstrb;
         beat_r   <= 4'd0;
         for (int i = 0; i < LINE_WORDS; i++) line_r[i] <= wr_data[32*i +: 32];
      end else if (w_hs_s) begin
         beat_r <= beat_r + 4'd1;
      end
   end

   // Current W beat word.
   always_comb begin
      wdata_s = 32'd0;
      for (int i = 0; i < LINE_WORDS; i++) begin
         wdata_s = wdata_s | (line_r[i] & {32{beat_r == 4'(i)}});
      end
   end

   assign axi.arid    = arid_r;
   assign axi.araddr  = araddr_r;
   assign axi.arlen   = arlen_r;
   assign axi.arsize  = arsize_r;
   assign axi.arburst = BURST_INCR;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'b0000;
   assign axi.arprot  = 3'b000;
   assign axi.arvalid = (ar_state_r == AR_SEND);
   assign axi.rready  = 1'b1;
   assign axi.awid    = 4'd0;
   assign axi.awaddr  = awaddr_r;
   assign axi.awlen   = awlen_r;
   assign axi.awsize  = awsize_r;
   assign axi.awburst = BURST_INCR;
   assign axi.awlock  = 2'b00;
   assign axi.awcache = 4'b0000;
   assign axi.awprot  = 3'b000;
   assign axi.awvalid = awvalid_s;
   assign axi.wid     = 4'd0;
   assign axi.wdata   = wdata_s;
   assign axi.wstrb   = wstrb_r;
   assign axi.wlast   = wlast_s;
   assign axi.wvalid  = wvalid_s;
   assign axi.bready  = bready_s;

endmodule
